// File: rtl/fp_pkg.sv
// Shared single-precision field definitions, operand struct, FSM states and rounding helper.
// FP_ACC_RNE_EN selects round-to-nearest-even; otherwise results round toward zero.
package fp_pkg;

   localparam int unsigned FP_EXP_W = 8;
   localparam int unsigned FP_MAN_W = 23;
   localparam int unsigned FP_BIAS  = 127;

   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W:0]   man;
   } fp_unpacked_t;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} fp_state_t;

   function automatic fp_unpacked_t fp_unpack(input logic [31:0] w);
      fp_unpacked_t u;
      u.sign = w[31];
      u.exp  = w[30:23];
      u.man  = {(w[30:23] != '0), w[22:0]};
      return u;
   endfunction

   function automatic logic fp_round_inc(input logic lsb, input logic g,
                                         input logic r, input logic s);
`ifdef FP_ACC_RNE_EN
      return g & (r | s | lsb);
`else
      return 1'b0;
`endif
   endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Product-in / sum-out bundle between the multiplier, the accumulator and its consumer.
interface fp_accumulator_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             acc_clr;
   logic [31:0]      acc_out;
   logic             acc_done;
   logic [CNT_W-1:0] term_cnt;

   modport master (
      output in_valid, in_data, acc_clr,
      input  in_ready, acc_out, acc_done, term_cnt
   );

   modport slave (
      input  in_valid, in_data, acc_clr,
      output in_ready, acc_out, acc_done, term_cnt
   );
endinterface

// File: rtl/fp_lzc28.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc28 (
   input  logic [27:0] i_data,
   output logic [4:0]  o_cnt
);
   always_comb begin
      o_cnt = 5'd28;
      for (int unsigned i = 0; i < 28; i++)
         if (i_data[i]) o_cnt = 5'(27 - i);
   end
endmodule

// File: rtl/fp_accumulator.sv
// Sequential IEEE-754 single accumulator: ALIGN/ADD/NORM/ROUND per accepted product word.
// Rounding follows FP_ACC_RNE_EN (nearest-even when defined, toward zero otherwise).
module fp_accumulator
   import fp_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   fp_accumulator_if.slave  bus
);

   fp_state_t        r_state, w_next;
   logic [31:0]      r_acc, r_in, r_byp_val, w_byp_val, w_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done, r_byp, w_byp, r_sign, r_sub, w_hs;
   logic [7:0]       r_ea, w_diff;
   logic [26:0]      r_ma, r_mb, w_lo27, w_shr, w_b27, r_n27, w_n27;
   logic [27:0]      r_sum, w_sum, w_lsh;
   logic [4:0]       w_lz;
   logic [24:0]      w_rm;
   logic [22:0]      w_rman;
   logic signed [9:0] r_e, w_e, w_re;
   logic             w_lost, w_a_big, w_inc;
   fp_unpacked_t     w_a, w_b, w_hi, w_lo;

   assign w_hs          = (r_state == IDLE) && bus.in_valid;
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.acc_out   = r_acc;
   assign bus.acc_done  = r_done;
   assign bus.term_cnt  = r_cnt;

   // ALIGN: order operands by magnitude and shift the smaller into a G/R/S field
   assign w_a     = fp_unpack(r_acc);
   assign w_b     = fp_unpack(r_in);
   assign w_a_big = r_acc[30:0] >= r_in[30:0];
   assign w_hi    = w_a_big ? w_a : w_b;
   assign w_lo    = w_a_big ? w_b : w_a;
   assign w_diff  = w_hi.exp - w_lo.exp;
   assign w_lo27  = {w_lo.man, 3'b000};
   assign w_shr   = w_lo27 >> w_diff;
   assign w_lost  = |(w_lo27 & ((27'd1 << w_diff) - 27'd1));
   assign w_b27   = (w_diff >= 8'd27) ? 27'd1 : {w_shr[26:1], w_shr[0] | w_lost};

   // Infinities and zero operands bypass the arithmetic path entirely
   always_comb begin
      w_byp     = 1'b1;
      w_byp_val = r_acc;
      if (w_a.exp == '1 || w_b.exp == '1) begin
         if (w_a.exp == '1 && w_b.exp == '1)
            w_byp_val = (w_a.sign & w_b.sign) ? FP_NEG_INF : FP_POS_INF;
         else if (w_a.exp == '1)
            w_byp_val = w_a.sign ? FP_NEG_INF : FP_POS_INF;
         else
            w_byp_val = w_b.sign ? FP_NEG_INF : FP_POS_INF;
      end else if (w_b.exp == '0) begin
         w_byp_val = (w_a.exp == '0) ? {w_a.sign & w_b.sign, 31'b0} : r_acc;
      end else if (w_a.exp == '0) begin
         w_byp_val = r_in;
      end else begin
         w_byp = 1'b0;
      end
   end

   assign w_sum = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});

   fp_lzc28 u_lzc (.i_data(r_sum), .o_cnt(w_lz));

   // NORM keeps the 27-bit hidden/mantissa/G/R/S framing, so the left shift is lz-1
   assign w_lsh = r_sum << (w_lz - 5'd1);
   always_comb begin
      if (r_sum[27]) begin
         w_n27 = {r_sum[27:2], r_sum[1] | r_sum[0]};
         w_e   = $signed(10'(r_ea)) + 10'sd1;
      end else begin
         w_n27 = w_lsh[26:0];
         w_e   = $signed(10'(r_ea)) - $signed(10'(w_lz)) + 10'sd1;
      end
   end

   assign w_inc  = fp_round_inc(r_n27[3], r_n27[2], r_n27[1], r_n27[0]);
   assign w_rm   = {1'b0, r_n27[26:3]} + 25'(w_inc);
   assign w_re   = w_rm[24] ? (r_e + 10'sd1) : r_e;
   assign w_rman = w_rm[24] ? w_rm[23:1] : w_rm[22:0];
   assign w_res  = r_byp ? r_byp_val :
                   (w_re >= 10'sd255) ? (r_sign ? FP_NEG_INF : FP_POS_INF) :
                   {r_sign, w_re[7:0], w_rman};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_next = ALIGN;
         ALIGN:   w_next = bus.acc_clr ? IDLE : ADD;
         ADD:     w_next = bus.acc_clr ? IDLE : NORM;
         NORM:    w_next = bus.acc_clr ? IDLE : ROUND;
         ROUND:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= FP_ZERO;  r_cnt <= '0;  r_done <= 1'b0;  r_in <= '0;
         r_byp <= 1'b0;     r_byp_val <= '0;  r_sign <= 1'b0;  r_sub <= 1'b0;
         r_ea <= '0;  r_ma <= '0;  r_mb <= '0;  r_sum <= '0;  r_n27 <= '0;  r_e <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.acc_clr) begin
            r_acc <= FP_ZERO;
            r_cnt <= '0;
         end
         case (r_state)
            IDLE: if (w_hs) r_in <= bus.in_data;
            ALIGN: begin
               r_byp     <= w_byp;
               r_byp_val <= w_byp_val;
               r_sign    <= w_hi.sign;
               r_sub     <= w_hi.sign ^ w_lo.sign;
               r_ea      <= w_hi.exp;
               r_ma      <= {w_hi.man, 3'b000};
               r_mb      <= w_b27;
            end
            ADD: r_sum <= w_sum;
            NORM: begin
               r_n27 <= w_n27;
               r_e   <= w_e;
               if (!r_byp) begin
                  if (r_sum == '0) begin
                     r_byp <= 1'b1;  r_byp_val <= FP_ZERO;
                  end else if (w_e <= 10'sd0) begin
                     r_byp <= 1'b1;  r_byp_val <= {r_sign, 31'b0};
                  end else if (w_e >= 10'sd255) begin
                     r_byp <= 1'b1;  r_byp_val <= r_sign ? FP_NEG_INF : FP_POS_INF;
                  end
               end
            end
            ROUND: if (!bus.acc_clr) begin
               r_acc  <= w_res;
               r_cnt  <= r_cnt + 1'b1;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: expected sums queued at drive time, checked on acc_done.
module tb_fp_accumulator;
   import fp_pkg::*;

   localparam int unsigned CNT_W = 16;
`ifdef FP_ACC_RNE_EN
   localparam logic [31:0] TIE_EXP = 32'h3F80_0002;
`else
   localparam logic [31:0] TIE_EXP = 32'h3F80_0001;
`endif

   logic clk = 1'b0;
   logic rst;

   fp_accumulator_if #(.CNT_W(CNT_W)) bus ();
   fp_accumulator #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] acc;
      logic [31:0] cnt;
      int unsigned hs;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (bus.acc_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'(bus.acc_done), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("acc_out", bus.acc_out, e.acc);
            check("term_cnt", 32'(bus.term_cnt), e.cnt);
            check("latency", cyc - e.hs, 32'd4);
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic clr,
                       input logic [31:0] exp_acc, input logic [31:0] exp_cnt, input bit track);
      int unsigned t = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.acc_clr  = clr;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.acc_clr  = 1'b0;
      bus.in_data  = $urandom();
      if (track) sb_q.push_back('{exp_acc, exp_cnt, cyc});
   endtask

   task automatic drain();
      int unsigned t = 0;
      while (sb_q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic clear();
      @(negedge clk);
      bus.acc_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.acc_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.acc_clr  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_acc", bus.acc_out, 32'h0);
      check("rst_cnt", 32'(bus.term_cnt), 32'd0);
      check("rst_done", 32'(bus.acc_done), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);

      send(32'h4020_0000, 1'b0, 32'h4020_0000, 32'd1, 1'b1);
      send(32'h4070_0000, 1'b0, 32'h40C8_0000, 32'd2, 1'b1);
      drain();
      send(32'h3F80_0000, 1'b1, 32'h3F80_0000, 32'd1, 1'b1);
      drain();

      clear();
      check("clr_acc", bus.acc_out, 32'h0);
      check("clr_cnt", 32'(bus.term_cnt), 32'd0);

      send(32'h40F0_0000, 1'b0, 32'h40F0_0000, 32'd1, 1'b1);
      send(32'hC0F0_0000, 1'b0, 32'h0000_0000, 32'd2, 1'b1);
      drain();

      clear();
      send(32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 32'd1, 1'b1);
      send(32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 32'd2, 1'b1);
      send(32'h3F80_0000, 1'b0, 32'h7F80_0000, 32'd3, 1'b1);
      drain();

      clear();
      send(32'h3F80_0001, 1'b0, 32'h3F80_0001, 32'd1, 1'b1);
      send(32'h3380_0000, 1'b0, TIE_EXP, 32'd2, 1'b1);
      drain();

      clear();
      send(32'hC049_0FDB, 1'b0, 32'hC049_0FDB, 32'd1, 1'b1);
      send(32'h0000_0000, 1'b0, 32'hC049_0FDB, 32'd2, 1'b1);
      send(32'h0040_0000, 1'b0, 32'hC049_0FDB, 32'd3, 1'b1);
      drain();

      clear();
      send(32'hFF80_0000, 1'b0, 32'hFF80_0000, 32'd1, 1'b1);
      send(32'h7F80_0000, 1'b0, 32'h7F80_0000, 32'd2, 1'b1);
      drain();

      clear();
      send(32'h3F80_0000, 1'b0, 32'h3F80_0000, 32'd1, 1'b1);
      send(32'hBE80_0000, 1'b0, 32'h3F40_0000, 32'd2, 1'b1);
      drain();

      send(32'h4000_0000, 1'b0, 32'h0, 32'd0, 1'b0);
      @(negedge clk);
      bus.acc_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.acc_clr = 1'b0;
      check("abort_acc", bus.acc_out, 32'h0);
      check("abort_cnt", 32'(bus.term_cnt), 32'd0);
      check("abort_ready", 32'(bus.in_ready), 32'd1);
      repeat (8) @(negedge clk);

      send(32'h3F80_0000, 1'b0, 32'h3F80_0000, 32'd1, 1'b1);
      drain();
      send(32'h4000_0000, 1'b0, 32'h0, 32'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_acc", bus.acc_out, 32'h0);
      check("rst_mid_cnt", 32'(bus.term_cnt), 32'd0);
      check("rst_mid_done", 32'(bus.acc_done), 32'd0);
      check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
